// File: rtl/poly_tone_synth_if.sv
// Programming and audio bundle between the control side and the tone synth.
// The master drives the per-channel programming; the slave produces audio/mix.
interface poly_tone_synth_if #(
  parameter int NCH = 4,
  parameter int HPW = 7
);
  localparam int MW = $clog2(NCH + 1);

  logic [NCH*HPW-1:0] hp;
  logic [NCH-1:0]     mode;
  logic [NCH-1:0]     active;
  logic [NCH-1:0]     audio;
  logic [MW-1:0]      mix;

  modport master (output hp, output mode, output active, input audio, input mix);
  modport slave  (input hp, input mode, input active, output audio, output mix);
endinterface

// File: rtl/poly_tone_synth.sv
// Multi-channel tone generator: every channel divides a shared slow tick by its
// own half-period and emits either a square wave or 15-bit LFSR noise. The gated
// audio bits and a registered count of high channels feed the PWM/DAC mixer.
module poly_tone_synth #(
  parameter int NCH = 4,
  parameter int HPW = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               synth_clk,
  poly_tone_synth_if.slave   bus
);
  localparam int MW = $clog2(NCH + 1);

  logic          s0, s1, prev;
  logic [1:0]    sync_fill;
  logic          tick;
  logic [NCH-1:0] tone_reg;
  logic [NCH-1:0] audio_w;
  logic [MW-1:0]  pop;
  logic [MW-1:0]  mix_q;

  // Synchronise synth_clk and keep the edge register pinned high until the
  // synchroniser holds a real sample, so a level already high at reset
  // release is not mistaken for a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0        <= 1'b0;
      s1        <= 1'b0;
      prev      <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      s0        <= synth_clk;
      s1        <= s0;
      sync_fill <= {sync_fill[0], 1'b1};
      prev      <= sync_fill[1] ? s1 : 1'b1;
    end
  end

  assign tick = s1 & ~prev;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [HPW-1:0] hp_ch;
    logic [HPW-1:0] ctr;
    logic [14:0]    lfsr;
    logic [14:0]    lfsr_step;
    logic           tone_q;

    assign hp_ch     = bus.hp[g*HPW +: HPW];
    assign lfsr_step = {lfsr[13:0], lfsr[14] ^ lfsr[13]};
    assign tone_reg[g] = tone_q;

    // Per-channel divider: expire when the counter reaches the half-period,
    // then toggle (square) or step the LFSR (noise); hp of zero mutes.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctr    <= HPW'(1);
        tone_q <= 1'b0;
        lfsr   <= 15'(g + 1);
      end else if (tick) begin
        if (hp_ch == '0) begin
          ctr    <= HPW'(1);
          tone_q <= 1'b0;
        end else if (ctr >= hp_ch) begin
          ctr <= HPW'(1);
          if (bus.mode[g]) begin
            lfsr   <= lfsr_step;
            tone_q <= lfsr_step[14];
          end else begin
            tone_q <= ~tone_q;
          end
        end else begin
          ctr <= ctr + HPW'(1);
        end
      end
    end
  end

  assign audio_w   = tone_reg & bus.active;
  assign bus.audio = audio_w;

  // Count how many gated channels are currently high.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NCH; i++) begin
      pop = pop + MW'(audio_w[i]);
    end
  end

  // Register the channel count for the mixer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mix_q <= '0;
    end else begin
      mix_q <= pop;
    end
  end

  assign bus.mix = mix_q;
endmodule
